// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_stage_if #(
   parameter int GPR_WIDTH = 32
);
   logic                 dmem_req;
   logic                 dmem_we;
   logic [GPR_WIDTH-1:0] dmem_addr;
   logic [GPR_WIDTH-1:0] dmem_wdata;
   logic [GPR_WIDTH-1:0] dmem_rdata;
   logic                 dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with timeout, branch resolution and
// registered write-back fields.
//
// state  | meaning
// IDLE   | accepting EX results; non-memory ops retire in one cycle
// ACCESS | memory request outstanding, upstream stalled
module mem_stage #(
   parameter int GPR_WIDTH      = 32,
   parameter int PC_WIDTH       = 32,
   parameter int GPR_ADDR_WIDTH = 4,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_mem_write_enable,
   input  logic                      in_sel_beq_bne,
   input  logic                      in_sel_jt_jf,
   input  logic                      in_is_branch,
   input  logic                      in_sel_jflag_branch,
   input  logic [2:0]                in_cond_sel,
   input  logic [1:0]                in_wb_res_mux,
   input  logic                      in_reg_write_enable,
   input  logic [GPR_WIDTH-1:0]      in_imm,
   input  logic [PC_WIDTH-1:0]       in_next_pc,
   input  logic [PC_WIDTH-1:0]       in_branch_addr,
   input  logic [GPR_WIDTH-1:0]      in_alu_res,
   input  logic [GPR_WIDTH-1:0]      in_mem_addr,
   input  logic [GPR_WIDTH-1:0]      in_mem_data,
   input  logic [5:0]                in_flags,
   input  logic [GPR_ADDR_WIDTH-1:0] in_reg_dest,
   output logic                      stall,
   mem_stage_if.master               dmem,
   output logic                      out_valid,
   output logic [1:0]                out_wb_res_mux,
   output logic                      out_reg_write_enable,
   output logic [GPR_ADDR_WIDTH-1:0] out_reg_dest,
   output logic [GPR_WIDTH-1:0]      out_alu_res,
   output logic [GPR_WIDTH-1:0]      out_mem_rdata,
   output logic [PC_WIDTH-1:0]       out_next_pc,
   output logic [GPR_WIDTH-1:0]      out_imm,
   output logic                      out_pc_src,
   output logic [PC_WIDTH-1:0]       out_branch_target,
   output logic                      mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic                      mem_op, taken, jflag_take, timeout_hit;
   logic [7:0]                flags_ext;

   logic                      hold_we;
   logic [1:0]                hold_wb_res_mux;
   logic                      hold_reg_write_enable;
   logic [GPR_ADDR_WIDTH-1:0] hold_reg_dest;
   logic [GPR_WIDTH-1:0]      hold_alu_res;
   logic [PC_WIDTH-1:0]       hold_next_pc;
   logic [GPR_WIDTH-1:0]      hold_imm;
   logic [GPR_WIDTH-1:0]      hold_addr;
   logic [GPR_WIDTH-1:0]      hold_wdata;

   // Decode of the incoming instruction: memory class and branch outcome.
   // Flag indices 6 and 7 read the zero padding and are forced not-taken.
   always_comb begin
      mem_op      = in_valid & (in_mem_write_enable | (in_wb_res_mux == 2'b01));
      flags_ext   = {2'b00, in_flags};
      jflag_take  = (in_cond_sel <= 3'd5) & (flags_ext[in_cond_sel] ^ in_sel_jt_jf);
      taken       = in_is_branch &
                    (in_sel_jflag_branch ? jflag_take : (in_flags[0] ^ in_sel_beq_bne));
      timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and bus outputs driven from the captured instruction.
   always_comb begin
      state_nxt        = state;
      stall            = (state == ACCESS);
      dmem.dmem_req    = (state == ACCESS);
      dmem.dmem_we     = hold_we;
      dmem.dmem_addr   = hold_addr;
      dmem.dmem_wdata  = hold_wdata;
      case (state)
         IDLE:    if (mem_op) state_nxt = ACCESS;
         ACCESS:  if (dmem.dmem_ack || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Hold register, timeout counter and registered write-back outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt                   <= '0;
         hold_we               <= 1'b0;
         hold_wb_res_mux       <= '0;
         hold_reg_write_enable <= 1'b0;
         hold_reg_dest         <= '0;
         hold_alu_res          <= '0;
         hold_next_pc          <= '0;
         hold_imm              <= '0;
         hold_addr             <= '0;
         hold_wdata            <= '0;
         out_valid             <= 1'b0;
         out_wb_res_mux        <= '0;
         out_reg_write_enable  <= 1'b0;
         out_reg_dest          <= '0;
         out_alu_res           <= '0;
         out_mem_rdata         <= '0;
         out_next_pc           <= '0;
         out_imm               <= '0;
         out_pc_src            <= 1'b0;
         out_branch_target     <= '0;
         mem_err               <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         out_pc_src <= 1'b0;
         if (state == IDLE) begin
            if (mem_op) begin
               cnt                   <= '0;
               hold_we               <= in_mem_write_enable;
               hold_wb_res_mux       <= in_wb_res_mux;
               hold_reg_write_enable <= in_reg_write_enable;
               hold_reg_dest         <= in_reg_dest;
               hold_alu_res          <= in_alu_res;
               hold_next_pc          <= in_next_pc;
               hold_imm              <= in_imm;
               hold_addr             <= in_mem_addr;
               hold_wdata            <= in_mem_data;
            end else if (in_valid) begin
               out_valid            <= 1'b1;
               out_wb_res_mux       <= in_wb_res_mux;
               out_reg_write_enable <= in_reg_write_enable;
               out_reg_dest         <= in_reg_dest;
               out_alu_res          <= in_alu_res;
               out_next_pc          <= in_next_pc;
               out_imm              <= in_imm;
               out_pc_src           <= taken;
               out_branch_target    <= in_branch_addr;
            end
         end else begin
            if (dmem.dmem_ack || timeout_hit) begin
               out_valid      <= 1'b1;
               out_wb_res_mux <= hold_wb_res_mux;
               out_reg_dest   <= hold_reg_dest;
               out_alu_res    <= hold_alu_res;
               out_next_pc    <= hold_next_pc;
               out_imm        <= hold_imm;
            end
            // Ack has priority over a coincident timeout.
            if (dmem.dmem_ack) begin
               out_reg_write_enable <= hold_reg_write_enable;
               out_mem_rdata        <= hold_we ? '0 : dmem.dmem_rdata;
            end else if (timeout_hit) begin
               out_reg_write_enable <= 1'b0;
               out_mem_rdata        <= '0;
               mem_err              <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
